instr_mem_pipe: RTL and testbench

Parametrised, synchronous-read instruction memory for the RISC-V core's fetch stage. It replaces the combinational instruction ROM with a one-cycle registered read behind a valid/ready handshake. It also provides a program-load write port, alignment and range fault reporting, redirect flush, and a count of accepted fetches. It sits between the PC/fetch unit and the decode stage.

---
 rtl/instr_mem_pipe_if.sv | 24 ++
 rtl/instr_mem_pipe.sv | 100 ++++++++++
 tb/tb_instr_mem_pipe.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_pipe_if.sv
// Fetch-side handshake bundle between the PC/fetch unit (master) and the
// registered instruction memory (slave).
interface instr_mem_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_pc;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_instr;
  logic [XLEN-1:0] resp_pc;
  logic [1:0]      resp_fault;

  modport master (
    output req_valid, req_pc, resp_ready,
    input  req_ready, resp_valid, resp_instr, resp_pc, resp_fault
  );

  modport slave (
    input  req_valid, req_pc, resp_ready,
    output req_ready, resp_valid, resp_instr, resp_pc, resp_fault
  );
endinterface

// File: rtl/instr_mem_pipe.sv
// Instruction memory with a one-cycle registered read behind valid/ready,
// program-load write port, fault reporting, redirect flush and fetch counter.
module instr_mem_pipe #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned XLEN      = 32,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] NOP       = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  instr_mem_pipe_if.slave          bus,
  input  logic                     flush,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  output logic [31:0]              fetch_count
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    FAULT_OK       = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  logic [31:0] mem [DEPTH];

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  fault_e          fault_q, fault_d;
  logic [31:0]     count_q, count_d;

  logic            ready;
  logic            accept;
  fault_e          req_fault;
  logic [AW-1:0]   req_idx;

  // Load port; the array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_comb begin
    ready   = !ld_en && (!valid_q || bus.resp_ready || flush);
    accept  = bus.req_valid && ready;
    req_idx = bus.req_pc[AW+1:2];
    if (bus.req_pc[1:0] != 2'b00) begin
      req_fault = FAULT_MISALIGN;
    end else if ((bus.req_pc >> (AW + 2)) != '0) begin
      req_fault = FAULT_RANGE;
    end else begin
      req_fault = FAULT_OK;
    end
  end

  // A new accept overrides drain/flush; otherwise only valid drops and the
  // payload registers keep their last values.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    count_d = count_q;
    if (accept) begin
      valid_d = 1'b1;
      pc_d    = bus.req_pc;
      fault_d = req_fault;
      instr_d = (req_fault == FAULT_OK) ? mem[req_idx] : NOP;
      count_d = count_q + 32'd1;
    end else if (valid_q && (bus.resp_ready || flush)) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP;
      pc_q    <= '0;
      fault_q <= FAULT_OK;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = valid_q;
  assign bus.resp_instr = instr_q;
  assign bus.resp_pc    = pc_q;
  assign bus.resp_fault = fault_q;
  assign fetch_count    = count_q;
endmodule

// File: tb/tb_instr_mem_pipe.sv
// Bench for instr_mem_pipe: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_instr_mem_pipe;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned XLEN  = 32;
  localparam logic [31:0] NOPI  = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] fetch_count;

  instr_mem_pipe_if #(.XLEN(XLEN)) bus ();

  instr_mem_pipe #(
    .DEPTH(DEPTH),
    .XLEN(XLEN),
    .INIT_FILE(""),
    .NOP(NOPI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .flush(flush),
    .ld_en(ld_en),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .fetch_count(fetch_count)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [31:0] model_mem [DEPTH];
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = NOPI;
  logic [31:0] m_pc    = '0;
  logic [1:0]  m_fault = 2'b00;
  logic [31:0] m_count = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fault_of(input logic [31:0] pc);
    if (pc % 4 != 0) return 2'b01;
    if (pc >= 4 * DEPTH) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic model_ready();
    return !ld_en && (!m_valid || bus.resp_ready || flush);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_instr = NOPI;
      m_pc    = '0;
      m_fault = 2'b00;
      m_count = '0;
    end else begin
      logic rdy;
      rdy = model_ready();
      if (bus.req_valid && rdy) begin
        m_valid = 1'b1;
        m_pc    = bus.req_pc;
        m_fault = fault_of(bus.req_pc);
        m_instr = (m_fault == 2'b00) ? model_mem[bus.req_pc / 4] : NOPI;
        m_count = m_count + 1;
      end else if (m_valid && (bus.resp_ready || flush)) begin
        m_valid = 1'b0;
      end
      if (ld_en) model_mem[ld_addr] = ld_data;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_resp_valid", bus.resp_valid, m_valid);
      chk("m_resp_instr", bus.resp_instr, m_instr);
      chk("m_resp_pc", bus.resp_pc, m_pc);
      chk("m_resp_fault", bus.resp_fault, m_fault);
      chk("m_fetch_count", fetch_count, m_count);
      chk("m_req_ready", bus.req_ready, model_ready());
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] stream_words [4];

  initial begin
    stream_words[0] = 32'h0010_0093;
    stream_words[1] = 32'h0020_0113;
    stream_words[2] = 32'h0020_81b3;
    stream_words[3] = 32'h4020_81b3;

    rst = 1'b1;
    flush = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    bus.req_valid = 1'b0;
    bus.req_pc = '0;
    bus.resp_ready = 1'b1;
    #12;
    chk("rst_valid", bus.resp_valid, 1'b0);
    chk("rst_instr", bus.resp_instr, 32'h13);
    chk("rst_pc", bus.resp_pc, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    rst = 1'b0;

    // Program load of the whole array
    tick();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ld_en = 1'b1;
      ld_addr = i[9:0];
      ld_data = (i < 4) ? stream_words[i] : $urandom;
      tick();
    end
    ld_en = 1'b0;
    tick();

    // Streamed fetch
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_pc = 32'(i * 4);
      tick();
      chk("stream_instr", bus.resp_instr, stream_words[i]);
      chk("stream_fault", bus.resp_fault, 2'b00);
    end
    chk("stream_count", fetch_count, 32'd4);

    // Backpressure
    bus.req_pc = 32'h4;
    tick();
    bus.resp_ready = 1'b0;
    bus.req_pc = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", bus.req_ready, 1'b0);
      tick();
      chk("bp_instr", bus.resp_instr, 32'h0020_0113);
      chk("bp_count", fetch_count, 32'd5);
    end
    bus.resp_ready = 1'b1;
    #1 chk("bp_release_ready", bus.req_ready, 1'b1);
    tick();
    chk("bp_next_instr", bus.resp_instr, 32'h0020_81b3);
    chk("bp_next_pc", bus.resp_pc, 32'h8);
    chk("bp_next_count", fetch_count, 32'd6);

    // Faults
    bus.req_pc = 32'h6;
    tick();
    chk("misalign_fault", bus.resp_fault, 2'b01);
    chk("misalign_instr", bus.resp_instr, 32'h13);
    bus.req_pc = 32'h1000;
    tick();
    chk("range_fault", bus.resp_fault, 2'b10);
    chk("range_instr", bus.resp_instr, 32'h13);
    chk("fault_count", fetch_count, 32'd8);
    bus.req_valid = 1'b0;
    tick();

    // Load with a competing request
    ld_en = 1'b1;
    ld_addr = 10'd5;
    ld_data = 32'h0020_e193;
    bus.req_valid = 1'b1;
    bus.req_pc = 32'h14;
    #1 chk("load_ready", bus.req_ready, 1'b0);
    tick();
    ld_en = 1'b0;
    #1 chk("after_load_ready", bus.req_ready, 1'b1);
    tick();
    chk("load_read_instr", bus.resp_instr, 32'h0020_e193);
    chk("load_read_count", fetch_count, 32'd9);

    // Flush/redirect over a stalled response
    bus.req_pc = 32'h8;
    tick();
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b0;
    tick();
    flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_pc = 32'h20;
    #1 chk("flush_ready", bus.req_ready, 1'b1);
    tick();
    chk("flush_pc", bus.resp_pc, 32'h20);
    chk("flush_valid", bus.resp_valid, 1'b1);
    bus.req_valid = 1'b0;
    tick();
    chk("flush_only_valid", bus.resp_valid, 1'b0);
    flush = 1'b0;
    bus.resp_ready = 1'b1;
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      r = $urandom_range(15);
      bus.req_valid = ($urandom_range(9) < 7);
      if (r < 12)      bus.req_pc = {20'd0, 10'($urandom), 2'b00};
      else if (r < 14) bus.req_pc = {20'd0, 10'($urandom), 2'($urandom_range(3, 1))};
      else             bus.req_pc = $urandom | 32'h0000_1000;
      bus.resp_ready = ($urandom_range(9) < 7);
      flush = ($urandom_range(9) == 0);
      ld_en = ($urandom_range(19) == 0);
      ld_addr = 10'($urandom);
      ld_data = $urandom;
      tick();
    end

    // Reset mid-stream
    ld_en = 1'b0;
    flush = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_pc = 32'h0;
    bus.resp_ready = 1'b0;
    tick();
    tick();
    chk("pre_rst_valid", bus.resp_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.resp_valid, 1'b0);
    chk("async_rst_instr", bus.resp_instr, 32'h13);
    chk("async_rst_pc", bus.resp_pc, 32'h0);
    chk("async_rst_count", fetch_count, 32'h0);
    #1 rst = 1'b0;
    bus.resp_ready = 1'b1;
    tick();
    chk("post_rst_valid", bus.resp_valid, 1'b1);
    chk("post_rst_count", fetch_count, 32'd1);
    bus.req_valid = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
